lsu_bus_master: RTL and testbench
=================================

Name: lsu_bus_master

Overview:
- Processor-side initiator for the external data-memory bus (DAD/MREQ/WRITE/SIZE/DDT/ACKD_n); the counterpart of the memory responder.
- Accepts one load/store request at a time from the MEM stage and converts it into a bus cycle. Waits any number of cycles for ACKD_n.
- Returns sign- or zero-extended load data, or reports a misalignment or timeout error.

Parameters:
- BIT_WIDTH, 32, address/data width
- TIMEOUT, 1024, max cycles waiting for ACKD_n before abort (>=2)
- CNT_W, 11, timeout counter width (>= clog2(TIMEOUT+1))

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block idle, request accepted this cycle if req_valid
- req_write  in  1  1=store, 0=load
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data (0 for stores/errors)
- resp_err  out  2  00 ok, 01 misaligned/illegal funct3, 10 timeout
- busy  out  1  stall request to pipeline (state != IDLE)
- DAD  out  32  bus address
- MREQ  out  1  bus request, active-high
- WRITE  out  1  1=write cycle
- SIZE  out  2  00 word, 01 half, 10 byte
- DDT  inout  32  bus data; driven only while MREQ&&WRITE, else high-Z
- ACKD_n  in  1  active-low acknowledge from memory

Behaviour:
- Reset (rst=0, async): state IDLE; MREQ=0, WRITE=0, SIZE=00, DAD=0, DDT high-Z, resp_valid=0, resp_rdata=0, resp_err=00, timeout counter=0. Reset mid-transaction abandons the cycle with no response.
- States: IDLE, BUS, RESP.
- IDLE: req_ready=1. On req_valid at the clock edge:
  - funct3 illegal (011, 110, 111; stores also reject 100/101), or W with addr[1:0]!=0, or H/HU with addr[0]!=0 -> RESP with err=01, no bus cycle.
  - Otherwise register DAD=req_addr, WRITE=req_write, SIZE from funct3 (W->00, H/HU->01, B/BU->10), MREQ=1, counter=0 -> BUS.
  - Store data register: W full word; H {16'b0, wdata[15:0]}; B {24'b0, wdata[7:0]}.
- BUS: outputs held stable. Each edge samples ACKD_n.
  - ACKD_n=0: capture DDT (loads), drop MREQ/WRITE next cycle -> RESP, err=00. Minimum latency request-accept to resp_valid = 2 cycles with a zero-wait responder.
  - Else counter++. Counter reaching TIMEOUT-1 without ack -> drop MREQ -> RESP, err=10.
- Load extension from captured DDT: W as-is; H sign-extend DDT[15:0]; HU zero-extend; B sign-extend DDT[7:0]; BU zero-extend. The bus delivers half/byte data in the low lanes; the block performs no lane shifting.
- RESP: resp_valid=1 for exactly one cycle, resp_rdata/resp_err valid with it -> IDLE. No request is accepted in RESP (req_ready=0). Back-to-back requests are therefore spaced by at least one idle cycle.
- DDT drives data only during BUS with WRITE=1; all other states high-Z. No contention with the responder on loads.
- ACKD_n=0 while in IDLE or RESP is ignored.
- Address 0xF000_0000 (stdout) and 0xFF00_0000 (exit) are ordinary addresses to this block.
- Address arithmetic is none; DAD equals req_addr bit-exact.

Test Plan:
- Responder with 1-cycle latency, lw at 0x0800_0000 holding bytes 12 34 56 78 -> MREQ=1, SIZE=00, WRITE=0 for one cycle; resp_rdata=0x12345678, err=00, resp_valid 2 cycles after accept.
- lb at 0x0800_0003 returning DDT=0x000000F0 -> SIZE=10, resp_rdata=0xFFFFFFF0. The same access with lbu -> 0x000000F0. lh returning 0x00008001 -> 0xFFFF8001.
- sb 0x41 to 0xF000_0000 -> DAD=0xF0000000, WRITE=1, SIZE=10, DDT=0x00000041 while MREQ; DDT high-Z after ack.
- lw at 0x0800_0002 -> no MREQ pulse, resp_valid with err=01. funct3=011 -> err=01.
- Responder never acks, TIMEOUT=8 -> MREQ high exactly 8 cycles, then resp err=10, rdata=0, back to IDLE with req_ready=1.
- 3-cycle-latency responder, rst pulled low during BUS -> MREQ=0 and DDT high-Z immediately; no resp_valid. The next request after reset completes normally.

Source files
------------

// File: rtl/lsu_bus_master.sv
// lsu_bus_master: MEM-stage load/store initiator for the DAD/DDT data-memory bus.
// One request at a time; waits for ACKD_n, extends load data, aborts after TIMEOUT cycles.
module lsu_bus_master #(
  parameter int BIT_WIDTH = 32,
  parameter int TIMEOUT   = 1024,
  parameter int CNT_W     = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [2:0]           req_funct3,
  input  logic [BIT_WIDTH-1:0] req_addr,
  input  logic [BIT_WIDTH-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [BIT_WIDTH-1:0] resp_rdata,
  output logic [1:0]           resp_err,
  output logic                 busy,
  output logic [BIT_WIDTH-1:0] DAD,
  output logic                 MREQ,
  output logic                 WRITE,
  output logic [1:0]           SIZE,
  inout  wire  [BIT_WIDTH-1:0] DDT,
  input  logic                 ACKD_n
);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [2:0]           r_f3;
  logic [BIT_WIDTH-1:0] r_wdata;
  logic [BIT_WIDTH-1:0] w_wdata;
  logic [BIT_WIDTH-1:0] w_ext;
  logic [1:0]           w_size;
  logic                 w_bad;
  // funct3[1] selects word, funct3[0] half, funct3[2] unsigned loads
  always_comb begin
    w_bad   = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) || (req_write && req_funct3[2]) ||
              (req_funct3[1] && req_addr[1:0] != 2'b00) || (req_funct3[0] && req_addr[0]);
    w_size  = req_funct3[1] ? 2'b00 : req_funct3[0] ? 2'b01 : 2'b10;
    w_wdata = req_funct3[1] ? req_wdata :
              req_funct3[0] ? {{(BIT_WIDTH-16){1'b0}}, req_wdata[15:0]} :
                              {{(BIT_WIDTH-8){1'b0}}, req_wdata[7:0]};
    w_ext   = r_f3[1] ? DDT :
              r_f3[0] ? {{(BIT_WIDTH-16){~r_f3[2] & DDT[15]}}, DDT[15:0]} :
                        {{(BIT_WIDTH-8){~r_f3[2] & DDT[7]}}, DDT[7:0]};
  end
  assign req_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign DDT       = (MREQ && WRITE) ? r_wdata : 'z;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_f3       <= '0;
      r_wdata    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 2'b00;
      DAD        <= '0;
      MREQ       <= 1'b0;
      WRITE      <= 1'b0;
      SIZE       <= 2'b00;
    end else begin
      case (r_state)
        IDLE: if (req_valid) begin
          r_f3 <= req_funct3;
          if (w_bad) begin
            resp_valid <= 1'b1;
            resp_err   <= 2'b01;
            resp_rdata <= '0;
            r_state    <= RESP;
          end else begin
            DAD     <= req_addr;
            WRITE   <= req_write;
            SIZE    <= w_size;
            MREQ    <= 1'b1;
            r_wdata <= w_wdata;
            r_cnt   <= '0;
            r_state <= BUS;
          end
        end
        BUS: if (!ACKD_n) begin
          MREQ       <= 1'b0;
          WRITE      <= 1'b0;
          resp_valid <= 1'b1;
          resp_err   <= 2'b00;
          resp_rdata <= WRITE ? '0 : w_ext;
          r_state    <= RESP;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          MREQ       <= 1'b0;
          WRITE      <= 1'b0;
          resp_valid <= 1'b1;
          resp_err   <= 2'b10;
          resp_rdata <= '0;
          r_state    <= RESP;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_err   <= 2'b00;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_bus_master.sv
// tb_lsu_bus_master: directed and random load/store transactions against a
// bus responder and an arithmetic reference model of the access rules.
module tb_lsu_bus_master;
  localparam int TO = 8;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, busy, MREQ, WRITE;
  logic [31:0] resp_rdata, DAD;
  logic [1:0]  resp_err, SIZE;
  wire  [31:0] DDT;
  logic        ACKD_n = 1'b1;
  logic        rs_drv = 1'b0;
  logic [31:0] rs_data = '0, rs_bd = '0;
  int          rs_lat = 1, rs_cnt = 0;
  bit          ack_force = 1'b0;
  int          checks = 0, failures = 0;

  lsu_bus_master #(.BIT_WIDTH(32), .TIMEOUT(TO), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .busy(busy), .DAD(DAD), .MREQ(MREQ), .WRITE(WRITE),
    .SIZE(SIZE), .DDT(DDT), .ACKD_n(ACKD_n)
  );

  assign DDT = rs_drv ? rs_data : 'z;
  always #5 clk = ~clk;

  // responder: acks in the rs_lat-th cycle of MREQ (never when rs_lat==0)
  always @(negedge clk) begin
    bit hit;
    rs_cnt  = MREQ ? rs_cnt + 1 : 0;
    hit     = MREQ && rs_lat != 0 && rs_cnt == rs_lat;
    ACKD_n  = !(hit || ack_force);
    rs_drv  = hit && !WRITE;
    rs_data = rs_bd;
  end

  function automatic void model(input bit w, input logic [2:0] f3, input logic [31:0] a, wd, bd,
                                output logic [1:0] err, output logic [31:0] rd, sd, output logic [1:0] sz);
    int n;
    longint lim, v;
    n = (f3 == 0 || f3 == 4) ? 1 : (f3 == 1 || f3 == 5) ? 2 : (f3 == 2) ? 4 : 0;
    if (w && f3 >= 4) n = 0;
    err = 2'd0;
    if (n == 0) err = 2'd1;
    else if (a % n != 0) err = 2'd1;
    sz  = (n == 4) ? 2'd0 : (n == 2) ? 2'd1 : 2'd2;
    lim = longint'(1) << (8 * n);
    sd  = 32'(longint'(wd) % lim);
    v   = longint'(bd) % lim;
    if (f3 < 4 && v >= lim / 2) v = v - lim;
    rd  = (w || err != 0) ? 32'd0 : 32'(v);
  endfunction

  task automatic do_txn(input string nm, input bit w, input logic [2:0] f3, input logic [31:0] a, wd, bd, input int lat);
    logic [1:0]  eerr, esz;
    logic [31:0] erd, esd;
    int m = 0, exp_m, kk = 0;
    bit got = 1'b0;
    model(w, f3, a, wd, bd, eerr, erd, esd, esz);
    if (lat == 0 && eerr == 0) begin eerr = 2'b10; erd = 0; end
    exp_m = (eerr == 2'b01) ? 0 : (lat == 0) ? TO : lat;
    rs_lat = lat; rs_bd = bd;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL %s ready_idle got=%b exp=1", nm, req_ready); end
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= TO + 10 && !got; k++) begin
      @(negedge clk);
      if (MREQ) begin
        m++;
        if (m == 1) begin
          checks++;
          if (DAD !== a || SIZE !== esz || WRITE !== w || busy !== 1'b1 || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s bus got dad=%h size=%b wr=%b busy=%b rdy=%b exp dad=%h size=%b wr=%b busy=1 rdy=0",
                     nm, DAD, SIZE, WRITE, busy, req_ready, a, esz, w);
          end
          if (w) begin
            checks++;
            if (DDT !== esd) begin failures++; $display("FAIL %s ddt got=%h exp=%h", nm, DDT, esd); end
          end
        end
      end
      if (resp_valid) begin
        got = 1'b1; kk = k;
        checks++;
        if (resp_err !== eerr || resp_rdata !== erd) begin
          failures++;
          $display("FAIL %s resp got err=%b rdata=%h exp err=%b rdata=%h", nm, resp_err, resp_rdata, eerr, erd);
        end
        checks++;
        if (kk != exp_m + 1 || m != exp_m) begin
          failures++;
          $display("FAIL %s timing got lat=%0d mreq=%0d exp lat=%0d mreq=%0d", nm, kk, m, exp_m + 1, exp_m);
        end
        checks++;
        if (MREQ !== 1'b0 || req_ready !== 1'b0 || (w && esd != 0 && DDT === esd)) begin
          failures++;
          $display("FAIL %s resp_state got mreq=%b rdy=%b ddt=%h exp mreq=0 rdy=0 ddt released", nm, MREQ, req_ready, DDT);
        end
      end
    end
    checks++;
    if (!got) begin failures++; $display("FAIL %s no_resp got=none exp=resp_valid", nm); end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== 32'd0) begin
      failures++;
      $display("FAIL %s after got vld=%b rdy=%b rdata=%h exp vld=0 rdy=1 rdata=0", nm, resp_valid, req_ready, resp_rdata);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (MREQ !== 0 || WRITE !== 0 || SIZE !== 0 || DAD !== 0 || resp_valid !== 0 || resp_rdata !== 0 ||
        resp_err !== 0 || req_ready !== 1 || busy !== 0) begin
      failures++;
      $display("FAIL reset got mreq=%b wr=%b size=%b dad=%h vld=%b rdata=%h err=%b rdy=%b busy=%b exp all idle",
               MREQ, WRITE, SIZE, DAD, resp_valid, resp_rdata, resp_err, req_ready, busy);
    end
    rst = 1'b1;
  endtask

  task automatic test_loads();
    do_txn("lw", 0, 3'b010, 32'h0800_0000, 0, 32'h1234_5678, 1);
    do_txn("lb", 0, 3'b000, 32'h0800_0003, 0, 32'h0000_00F0, 1);
    do_txn("lbu", 0, 3'b100, 32'h0800_0003, 0, 32'h0000_00F0, 1);
    do_txn("lh", 0, 3'b001, 32'h0800_0002, 0, 32'h0000_8001, 2);
    do_txn("lhu", 0, 3'b101, 32'h0800_0002, 0, 32'hABCD_8001, 3);
    do_txn("lw_exit", 0, 3'b010, 32'hFF00_0000, 0, 32'hDEAD_BEEF, 4);
  endtask

  task automatic test_store();
    do_txn("sb_stdout", 1, 3'b000, 32'hF000_0000, 32'h1234_5641, 0, 1);
    do_txn("sh", 1, 3'b001, 32'h0000_0102, 32'hFFFF_A5A5, 0, 2);
    do_txn("sw", 1, 3'b010, 32'h0000_0204, 32'h8765_4321, 0, 3);
  endtask

  task automatic test_errors();
    do_txn("lw_mis", 0, 3'b010, 32'h0800_0002, 0, 32'h1, 1);
    do_txn("f3_011", 0, 3'b011, 32'h0800_0000, 0, 32'h1, 1);
    do_txn("lh_mis", 0, 3'b001, 32'h0800_0001, 0, 32'h1, 1);
    do_txn("sbu_bad", 1, 3'b100, 32'h0800_0000, 32'h55, 0, 1);
    do_txn("f3_111", 1, 3'b111, 32'h0800_0000, 32'h55, 0, 1);
  endtask

  task automatic test_timeout();
    do_txn("timeout_ld", 0, 3'b010, 32'h0000_0200, 0, 32'h1111_1111, 0);
    do_txn("timeout_st", 1, 3'b000, 32'h0000_0201, 32'h77, 0, 0);
  endtask

  task automatic test_ack_ignored();
    ack_force = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if (MREQ !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        failures++;
        $display("FAIL ack_idle got mreq=%b vld=%b rdy=%b exp 0 0 1", MREQ, resp_valid, req_ready);
      end
    end
    ack_force = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_bus();
    int m = 0;
    rs_lat = 3; rs_bd = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h100; req_wdata = 32'hCAFE_BABE;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 0; k < 6 && m < 2; k++) begin
      @(negedge clk);
      if (MREQ) m++;
    end
    checks++;
    if (m != 2 || DDT !== 32'hCAFE_BABE) begin
      failures++;
      $display("FAIL rst_pre got mreq_cycles=%0d ddt=%h exp 2 cafebabe", m, DDT);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (MREQ !== 1'b0 || DDT === 32'hCAFE_BABE || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid got mreq=%b ddt=%h busy=%b exp mreq=0 ddt released busy=0", MREQ, DDT, busy);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_noresp got vld=%b exp 0", resp_valid); end
    end
    rst = 1'b1;
    do_txn("post_rst", 0, 3'b000, 32'h0800_0001, 0, 32'h0000_007F, 3);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      int lat;
      a   = $urandom;
      lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4));
      do_txn($sformatf("rnd%0d", i), 1'($urandom), 3'($urandom), a, $urandom, $urandom, lat);
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_store();
    test_errors();
    test_timeout();
    test_ack_ignored();
    test_reset_mid_bus();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
